// File: rtl/regs_access_arbiter.sv
// Arbitrates the simple-dual-port register RAM between the AXI bridge, which can never be
// stalled, and the internal host FSMs, which use a req/gnt handshake.
module regs_access_arbiter #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [ADDR_BITS-1:0]   a_waddr,
  input  logic [DATA_BITS-1:0]   a_wdata,
  input  logic [DATA_BITS/8-1:0] a_wstb,
  input  logic                   a_wen,
  input  logic [ADDR_BITS-1:0]   a_raddr,
  input  logic                   a_ren,
  input  logic                   a_regen,
  output logic [DATA_BITS-1:0]   a_rdata,
  input  logic                   h_req,
  input  logic                   h_we,
  input  logic [ADDR_BITS-1:0]   h_addr,
  input  logic [DATA_BITS-1:0]   h_wdata,
  input  logic [DATA_BITS/8-1:0] h_wstb,
  output logic                   h_gnt,
  output logic [DATA_BITS-1:0]   h_rdata,
  output logic                   h_rvalid,
  output logic [ADDR_BITS-1:0]   ram_waddr,
  output logic [DATA_BITS-1:0]   ram_wdata,
  output logic [DATA_BITS/8-1:0] ram_wstb,
  output logic                   ram_we,
  output logic [ADDR_BITS-1:0]   ram_raddr,
  output logic                   ram_re,
  input  logic [DATA_BITS-1:0]   ram_rdata,
  output logic [1:0]             state
);

  // Handshake: h_req is held with stable h_we/h_addr/h_wdata/h_wstb until h_gnt is seen
  // high for one cycle; that cycle issues the RAM access. A host read returns h_rdata with
  // a one-cycle h_rvalid pulse two cycles after h_gnt. AXI accesses are never refused.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  state_t cur_state, nxt_state;
  logic   a_rd_pend;
  logic   h_wr_gnt, h_rd_gnt;

  assign state = cur_state;

  // A host read must also avoid the cycle where the AXI read data is being captured.
  assign h_wr_gnt = (cur_state == IDLE) && h_req && h_we && !a_wen;
  assign h_rd_gnt = (cur_state == IDLE) && h_req && !h_we && !a_ren && !a_rd_pend;

  always_comb begin
    nxt_state = cur_state;
    h_gnt     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = a_waddr;
    ram_wdata = a_wdata;
    ram_wstb  = a_wstb;
    ram_raddr = a_raddr;
    if (ARESETN) begin
      h_gnt  = h_wr_gnt || h_rd_gnt;
      ram_we = a_wen || h_wr_gnt;
      ram_re = a_ren || h_rd_gnt;
    end
    if (!a_wen) begin
      ram_waddr = h_addr;
      ram_wdata = h_wdata;
      ram_wstb  = h_wstb;
    end
    if (!a_ren) ram_raddr = h_addr;
    case (cur_state)
      IDLE:    if (h_rd_gnt) nxt_state = RD_WAIT;
      RD_WAIT: nxt_state = RD_DONE;
      RD_DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cur_state <= IDLE;
      a_rd_pend <= 1'b0;
      a_rdata   <= '0;
      h_rdata   <= '0;
      h_rvalid  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (a_ren)        a_rd_pend <= 1'b1;
      else if (a_regen) a_rd_pend <= 1'b0;
      if (a_regen) a_rdata <= ram_rdata;
      // RAM output for the host read is valid throughout RD_WAIT.
      if (cur_state == RD_WAIT) h_rdata <= ram_rdata;
      h_rvalid <= (cur_state == RD_WAIT);
    end
  end

endmodule
